// File: rtl/cache_bank_requester_pkg.sv
// Shared types and defaults for the cache bank requester: FSM encoding, FIFO depth, retry limit.
// The verify states exist only when CACHE_REQ_WRITE_VERIFY_EN is defined.
`timescale 1ns/1ps
package cache_bank_requester_pkg;

    localparam int DEFAULT_DATA_WIDTH  = 8;
    localparam int DEFAULT_ADDR_WIDTH  = 8;
    localparam int DEFAULT_MAX_RETRIES = 3;
    localparam int FIFO_DEPTH          = 2;
    localparam int FIFO_CNT_W          = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [2:0] {
        ST_IDLE          = 3'd0,
        ST_ISSUE         = 3'd1,
        ST_SAMPLE        = 3'd2,
`ifdef CACHE_REQ_WRITE_VERIFY_EN
        ST_VERIFY_ISSUE  = 3'd3,
        ST_VERIFY_SAMPLE = 3'd4,
`endif
        ST_RESP          = 3'd5
    } state_t;

endpackage

// File: rtl/cache_req_fifo.sv
// Two-entry {write, addr, data} request buffer. Push/pop legality is decided by the parent.
`timescale 1ns/1ps
module cache_req_fifo
    import cache_bank_requester_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic                  pop,
    input  logic                  pushWrite,
    input  logic [ADDR_WIDTH-1:0] pushAddr,
    input  logic [DATA_WIDTH-1:0] pushData,
    output logic                  headWrite,
    output logic [ADDR_WIDTH-1:0] headAddr,
    output logic [DATA_WIDTH-1:0] headData,
    output logic [FIFO_CNT_W-1:0] count,
    output logic                  full,
    output logic                  empty
);

    logic [FIFO_DEPTH-1:0] writeMem;
    logic [ADDR_WIDTH-1:0] addrMem [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] dataMem [FIFO_DEPTH];
    logic                  wrPtr;
    logic                  rdPtr;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wrPtr    <= 1'b0;
            rdPtr    <= 1'b0;
            count    <= '0;
            writeMem <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                addrMem[i] <= '0;
                dataMem[i] <= '0;
            end
        end else begin
            if (push) begin
                writeMem[wrPtr] <= pushWrite;
                addrMem[wrPtr]  <= pushAddr;
                dataMem[wrPtr]  <= pushData;
                wrPtr           <= ~wrPtr;
            end
            if (pop) begin
                rdPtr <= ~rdPtr;
            end
            count <= count + FIFO_CNT_W'(push) - FIFO_CNT_W'(pop);
        end
    end

    assign headWrite = writeMem[rdPtr];
    assign headAddr  = addrMem[rdPtr];
    assign headData  = dataMem[rdPtr];
    assign full      = (count == FIFO_CNT_W'(FIFO_DEPTH));
    assign empty     = (count == '0);

endmodule

// File: rtl/cache_bank_requester.sv
// Initiator for one cacheBank port: buffers client requests, drives the bank, retries lost writes.
// Define CACHE_REQ_WRITE_VERIFY_EN to read back every successful write and flag mismatches.
`timescale 1ns/1ps
module cache_bank_requester
    import cache_bank_requester_pkg::*;
#(
    parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH  = DEFAULT_ADDR_WIDTH,
    parameter int MAX_RETRIES = DEFAULT_MAX_RETRIES
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_data,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  rsp_error,
    output logic                  busy,
    output logic [ADDR_WIDTH-1:0] cacheAddressIn,
    output logic [DATA_WIDTH-1:0] cacheDataIn,
    output logic                  memWrite,
    input  logic [DATA_WIDTH-1:0] cacheDataOut,
    input  logic                  portWrittenTo,
    output state_t                dbgState
);

    localparam int RETRY_W = $clog2(MAX_RETRIES + 1);

    // Handshake: a request transfers on any rising edge where req_valid && req_ready;
    // req_ready is registered and only reflects free FIFO space, so a same-cycle pop never frees a slot.
    state_t                state;
    logic                  readyReg;
    logic                  holdWrite;
    logic [ADDR_WIDTH-1:0] holdAddr;
    logic [DATA_WIDTH-1:0] holdData;
    logic [DATA_WIDTH-1:0] readData;
    logic [RETRY_W-1:0]    retryCnt;
    logic                  errorFlag;

    logic                  fifoPush;
    logic                  fifoPop;
    logic                  headWrite;
    logic [ADDR_WIDTH-1:0] headAddr;
    logic [DATA_WIDTH-1:0] headData;
    logic [FIFO_CNT_W-1:0] fifoCount;
    logic [FIFO_CNT_W-1:0] countNext;
    logic                  fifoFull;
    logic                  fifoEmpty;

    assign fifoPush  = req_valid && readyReg;
    assign fifoPop   = (state == ST_IDLE) && !fifoEmpty;
    assign countNext = fifoCount + FIFO_CNT_W'(fifoPush) - FIFO_CNT_W'(fifoPop);

    cache_req_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (fifoPush),
        .pop       (fifoPop),
        .pushWrite (req_write),
        .pushAddr  (req_addr),
        .pushData  (req_data),
        .headWrite (headWrite),
        .headAddr  (headAddr),
        .headData  (headData),
        .count     (fifoCount),
        .full      (fifoFull),
        .empty     (fifoEmpty)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            readyReg <= 1'b0;
        end else begin
            readyReg <= (countNext != FIFO_CNT_W'(FIFO_DEPTH));
        end
    end

    // Bank-facing outputs are registered on the edge that enters the state they belong to.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= ST_IDLE;
            holdWrite      <= 1'b0;
            holdAddr       <= '0;
            holdData       <= '0;
            readData       <= '0;
            retryCnt       <= '0;
            errorFlag      <= 1'b0;
            cacheAddressIn <= '0;
            cacheDataIn    <= '0;
            memWrite       <= 1'b0;
            rsp_valid      <= 1'b0;
            rsp_data       <= '0;
            rsp_error      <= 1'b0;
        end else begin
            memWrite  <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_error <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (!fifoEmpty) begin
                        holdWrite      <= headWrite;
                        holdAddr       <= headAddr;
                        holdData       <= headData;
                        retryCnt       <= '0;
                        errorFlag      <= 1'b0;
                        cacheAddressIn <= headAddr;
                        cacheDataIn    <= headData;
                        memWrite       <= headWrite;
                        state          <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    state <= ST_SAMPLE;
                end
                ST_SAMPLE: begin
                    if (!holdWrite) begin
                        readData <= cacheDataOut;
                        state    <= ST_RESP;
                    end else if (portWrittenTo) begin
`ifdef CACHE_REQ_WRITE_VERIFY_EN
                        state <= ST_VERIFY_ISSUE;
`else
                        state <= ST_RESP;
`endif
                    end else if (retryCnt < RETRY_W'(MAX_RETRIES)) begin
                        retryCnt <= retryCnt + RETRY_W'(1);
                        memWrite <= 1'b1;
                        state    <= ST_ISSUE;
                    end else begin
                        errorFlag <= 1'b1;
                        state     <= ST_RESP;
                    end
                end
`ifdef CACHE_REQ_WRITE_VERIFY_EN
                // Address is still held from the write, so this cycle is a plain read of it.
                ST_VERIFY_ISSUE: begin
                    state <= ST_VERIFY_SAMPLE;
                end
                ST_VERIFY_SAMPLE: begin
                    if (cacheDataOut != holdData) begin
                        errorFlag <= 1'b1;
                    end
                    state <= ST_RESP;
                end
`endif
                ST_RESP: begin
                    rsp_valid <= 1'b1;
                    rsp_data  <= holdWrite ? holdData : readData;
                    rsp_error <= errorFlag;
                    state     <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready = readyReg;
    assign busy      = (state != ST_IDLE) || !fifoEmpty;
    assign dbgState  = state;

endmodule

// File: tb/tb_cache_bank_requester.sv
// Directed bench for cache_bank_requester with a behavioural bank port and an in-order response scoreboard.
`timescale 1ns/1ps
module tb_cache_bank_requester;
    import cache_bank_requester_pkg::*;

    localparam int DW = 8;
    localparam int AW = 8;
`ifdef CACHE_REQ_WRITE_VERIFY_EN
    localparam int VX = 2;
`else
    localparam int VX = 0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_write = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_data = '0;
    logic          rsp_valid;
    logic [DW-1:0] rsp_data;
    logic          rsp_error;
    logic          busy;
    logic [AW-1:0] cacheAddressIn;
    logic [DW-1:0] cacheDataIn;
    logic          memWrite;
    logic [DW-1:0] cacheDataOut = '0;
    logic          portWrittenTo = 1'b0;
    state_t        dbgState;

    int passCount  = 0;
    int checkCount = 0;
    int failCount  = 0;

    logic [DW:0] exp_q[$];
    logic [DW:0] expEntry;
    int rspCount   = 0;
    int rspCyc     = 0;
    int lastAccept = 0;
    int cyc        = 0;
    logic prevMw   = 1'b0;

    // Bank port model: loses the first loseFirst attempts counted from attemptBase.
    logic [DW-1:0] bankMem [256];
    int   totalAttempts = 0;
    int   attemptBase   = 0;
    int   loseFirst     = 0;
    logic corrupt       = 1'b0;
    logic bankWin;

    cache_bank_requester dut (
        .clk            (clk),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_write      (req_write),
        .req_addr       (req_addr),
        .req_data       (req_data),
        .rsp_valid      (rsp_valid),
        .rsp_data       (rsp_data),
        .rsp_error      (rsp_error),
        .busy           (busy),
        .cacheAddressIn (cacheAddressIn),
        .cacheDataIn    (cacheDataIn),
        .memWrite       (memWrite),
        .cacheDataOut   (cacheDataOut),
        .portWrittenTo  (portWrittenTo),
        .dbgState       (dbgState)
    );

    // clock / cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign bankWin = (totalAttempts - attemptBase) >= loseFirst;

    always @(posedge clk) begin
        if (memWrite && bankWin) bankMem[cacheAddressIn] <= cacheDataIn;
        if (memWrite) totalAttempts <= totalAttempts + 1;
        portWrittenTo <= memWrite && bankWin;
        cacheDataOut  <= corrupt ? 8'hFF : bankMem[cacheAddressIn];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCount++;
        assert (obs === exp) passCount++;
        else begin
            failCount++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // scoreboard / monitor
    always @(negedge clk) begin
        if (reset && memWrite) check("memwrite_single_cycle", 32'(prevMw), 32'd0);
        prevMw = memWrite;
        if (rsp_valid) begin
            rspCount++;
            rspCyc = cyc;
            if (exp_q.size() == 0) begin
                check("rsp_unexpected", 32'd1, 32'd0);
            end else begin
                expEntry = exp_q.pop_front();
                check("rsp_data", 32'(rsp_data), 32'(expEntry[DW-1:0]));
                check("rsp_error", 32'(rsp_error), 32'(expEntry[DW]));
            end
        end
    end

    task automatic send(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic [DW:0] exp, input bit expectRsp);
        int t;
        @(negedge clk);
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_data  = d;
        t = 0;
        while (!req_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!req_ready) begin
            check("req_ready_timeout", 32'd0, 32'd1);
            req_valid = 1'b0;
        end else begin
            if (expectRsp) exp_q.push_back(exp);
            @(posedge clk);
            #1;
            lastAccept = cyc;
            req_valid  = 1'b0;
        end
    endtask

    task automatic wait_rsp(input int target, input int limit);
        int t;
        t = 0;
        while (rspCount < target && t < limit) begin
            @(negedge clk);
            #1;
            t++;
        end
        check("rsp_count", 32'(rspCount), 32'(target));
    endtask

    task automatic txn(input string tag, input logic w, input logic [AW-1:0] a, input logic [DW:0] exp,
                       input int lat, input int pulses);
        int startCount;
        startCount  = rspCount;
        attemptBase = totalAttempts;
        send(w, a, exp[DW-1:0], exp, 1'b1);
        wait_rsp(startCount + 1, 40);
        check({tag, "_latency"}, 32'(rspCyc - lastAccept), 32'(lat));
        check({tag, "_pulses"}, 32'(totalAttempts - attemptBase), 32'(pulses));
        @(negedge clk);
        #1;
        check({tag, "_rsp_one_cycle"}, 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        int t;
        int base;
        // reset
        repeat (3) @(negedge clk);
        check("reset_req_ready", 32'(req_ready), 32'd0);
        check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset_memwrite", 32'(memWrite), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_addr", 32'(cacheAddressIn), 32'd0);
        check("reset_state", 32'(dbgState), 32'(ST_IDLE));
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check("ready_after_reset", 32'(req_ready), 32'd1);

        // single transactions: write then read back, first-try write, lost writes
        loseFirst = 0;
        txn("wr_04", 1'b1, 8'h04, {1'b0, 8'h02}, 4 + VX, 1);
        txn("rd_04", 1'b0, 8'h04, {1'b0, 8'h02}, 4, 0);
        txn("wr_06", 1'b1, 8'h06, {1'b0, 8'h03}, 4 + VX, 1);
        txn("rd_06", 1'b0, 8'h06, {1'b0, 8'h03}, 4, 0);
        loseFirst = 2;
        txn("wr_retry2", 1'b1, 8'h08, {1'b0, 8'h05}, 8 + VX, 3);
        loseFirst = 0;
        txn("rd_08", 1'b0, 8'h08, {1'b0, 8'h05}, 4, 0);
        loseFirst = 1000;
        txn("wr_fail", 1'b1, 8'h09, {1'b1, 8'h07}, 10, 4);
        loseFirst = 0;
        check("idle_busy", 32'(busy), 32'd0);

        // three back-to-back requests: FIFO fills, order preserved
        base = rspCount;
        send(1'b0, 8'h04, 8'h00, {1'b0, 8'h02}, 1'b1);
        send(1'b1, 8'h0A, 8'h09, {1'b0, 8'h09}, 1'b1);
        send(1'b0, 8'h0A, 8'h00, {1'b0, 8'h09}, 1'b1);
        check("ready_low_full", 32'(req_ready), 32'd0);
        check("busy_full", 32'(busy), 32'd1);
        wait_rsp(base + 3, 80);

        // reset dropped mid-write while in ISSUE
        base = rspCount;
        send(1'b1, 8'h0C, 8'h04, {1'b0, 8'h04}, 1'b0);
        t = 0;
        @(negedge clk);
        while (dbgState != ST_ISSUE && t < 10) begin
            @(negedge clk);
            t++;
        end
        check("reached_issue", 32'(dbgState), 32'(ST_ISSUE));
        check("issue_memwrite", 32'(memWrite), 32'd1);
        reset = 1'b0;
        #1;
        check("rst_memwrite_now", 32'(memWrite), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_state", 32'(dbgState), 32'(ST_IDLE));
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (6) @(negedge clk);
        #1;
        check("rst_ready_after", 32'(req_ready), 32'd1);
        check("rst_no_rsp", 32'(rspCount), 32'(base));
        check("rst_busy_after", 32'(busy), 32'd0);

`ifdef CACHE_REQ_WRITE_VERIFY_EN
        // readback mismatch on a successful write
        corrupt = 1'b1;
        txn("wr_verify_bad", 1'b1, 8'h0D, {1'b1, 8'h01}, 4 + VX, 1);
        corrupt = 1'b0;
`endif

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
